pic_priority_core: RTL and testbench

PIC_PRIORITY_CORE -- requirements
Module: pic_priority_core

---
 rtl/pic_pkg.sv | 21 ++
 rtl/pic_prio_sel.sv | 35 +++
 rtl/pic_priority_core.sv | 149 ++++++++++++++
 tb/tb_pic_priority_core.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the priority interrupt controller.
package pic_pkg;

  localparam int unsigned NIrqMin = 2;
  localparam int unsigned NIrqMax = 16;
  localparam int unsigned IdxWMax = $clog2(NIrqMax);

  typedef enum logic [1:0] {
    StIdle,
    StAck1,
    StAck2
  } pic_state_e;

  function automatic logic [NIrqMax-1:0] idx_to_onehot(input logic [IdxWMax-1:0] idx);
    logic [NIrqMax-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/pic_prio_sel.sv
// Rotating priority search: first request after ptr_i that beats every in-service line.
module pic_prio_sel
  import pic_pkg::*;
#(
  parameter int unsigned N_IRQ = 8,
  localparam int unsigned IDX_W = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req_i,
  input  logic [N_IRQ-1:0] isr_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             isr_hit;
  logic [IDX_W-1:0] pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    isr_hit = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      pos = IDX_W'((32'(ptr_i) + k + 32'd1) % N_IRQ);
      // An in-service line at or above a request blocks it (strictly-higher rule).
      if (isr_i[pos]) begin
        isr_hit = 1'b1;
      end else if (!isr_hit && !found_o && req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/pic_priority_core.sv
// Priority interrupt controller core: request capture, nesting, two-pulse acknowledge, EOI.
module pic_priority_core
  import pic_pkg::*;
#(
  parameter int unsigned N_IRQ = 8,
  localparam int unsigned IDX_W = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] imr_i,
  input  logic             init_done_i,
  input  logic             level_mode_i,
  input  logic             rotate_en_i,
  input  logic             aeoi_i,
  input  logic [7-IDX_W:0] vec_base_i,
  input  logic             inta_i,
  input  logic             eoi_valid_i,
  input  logic             eoi_specific_i,
  input  logic [IDX_W-1:0] eoi_level_i,
  output logic             int_o,
  output logic             vec_valid_o,
  output logic [7:0]       vec_data_o,
  output logic [N_IRQ-1:0] irr_o,
  output logic [N_IRQ-1:0] isr_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_IRQ - 1);

  function automatic logic [N_IRQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NIrqMax-1:0] full;
    full = idx_to_onehot(IdxWMax'(i));
    return full[N_IRQ-1:0];
  endfunction

  logic [N_IRQ-1:0] irq_q, irr_q, irr_d, isr_q, isr_d, ack_clr;
  logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d;
  pic_state_e       state_q, state_d;
  logic             int_q, int_d, vec_valid_q, vec_valid_d;
  logic [7:0]       vec_data_q, vec_data_d;
  logic             win_found, hi_found;
  logic [IDX_W-1:0] win_idx, hi_idx;

  pic_prio_sel #(.N_IRQ(N_IRQ)) u_win_sel (
    .req_i   (irr_q & ~imr_i),
    .isr_i   (isr_q),
    .ptr_i   (ptr_q),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  // Same search with no blocking finds the highest-priority in-service line for EOI.
  pic_prio_sel #(.N_IRQ(N_IRQ)) u_eoi_sel (
    .req_i   (isr_q),
    .isr_i   ('0),
    .ptr_i   (ptr_q),
    .found_o (hi_found),
    .idx_o   (hi_idx)
  );

  always_comb begin
    isr_d       = isr_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    state_d     = state_q;
    vec_valid_d = 1'b0;
    vec_data_d  = vec_data_q;
    ack_clr     = '0;

    // EOI lands before any acknowledge set in the same cycle.
    if (eoi_valid_i) begin
      if (eoi_specific_i) begin
        if (isr_q[eoi_level_i]) begin
          isr_d[eoi_level_i] = 1'b0;
          ptr_d              = eoi_level_i;
        end
      end else if (hi_found) begin
        isr_d[hi_idx] = 1'b0;
        ptr_d         = hi_idx;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (init_done_i && inta_i) begin
          state_d = StAck1;
          if (win_found) begin
            idx_d   = win_idx;
            isr_d   = isr_d | onehot(win_idx);
            ack_clr = onehot(win_idx);
          end else begin
            idx_d = LastIdx;
          end
        end
      end
      StAck1: begin
        if (init_done_i && inta_i) begin
          state_d     = StAck2;
          vec_valid_d = 1'b1;
          vec_data_d  = {vec_base_i, idx_q};
          if (aeoi_i && isr_d[idx_q]) begin
            isr_d[idx_q] = 1'b0;
            ptr_d        = idx_q;
          end
        end
      end
      StAck2:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (!init_done_i) state_d = StIdle;
    if (!rotate_en_i) ptr_d = LastIdx;

    // A fresh edge wins over the acknowledge clear of the same line.
    irr_d = level_mode_i ? irq_i : ((irr_q & ~ack_clr) | (irq_i & ~irq_q));
    int_d = init_done_i && (state_d == StIdle) && win_found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q       <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      ptr_q       <= LastIdx;
      idx_q       <= '0;
      state_q     <= StIdle;
      int_q       <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_data_q  <= '0;
    end else begin
      irq_q       <= irq_i;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      int_q       <= int_d;
      vec_valid_q <= vec_valid_d;
      vec_data_q  <= vec_data_d;
    end
  end

  assign int_o       = int_q;
  assign vec_valid_o = vec_valid_q;
  assign vec_data_o  = vec_data_q;
  assign irr_o       = irr_q;
  assign isr_o       = isr_q;

endmodule

// File: tb/tb_pic_priority_core.sv
// Directed bench for pic_priority_core at N_IRQ=8 and N_IRQ=16.
module tb_pic_priority_core;

  logic        clk;
  logic        rst8_n, rst16_n;
  logic [7:0]  irq8, irr8, isr8, vdata8;
  logic [15:0] irq16, irr16, isr16;
  logic [7:0]  vdata16;
  logic        init_done, level_mode, rotate_en, aeoi, inta;
  logic        eoi_valid, eoi_specific;
  logic [2:0]  eoi_level8;
  logic        int8, vvalid8, int16, vvalid16;

  int n_checks = 0;
  int n_pass   = 0;

  pic_priority_core #(.N_IRQ(8)) u_dut8 (
    .clk            (clk),
    .rst_n          (rst8_n),
    .irq_i          (irq8),
    .imr_i          (8'h00),
    .init_done_i    (init_done),
    .level_mode_i   (level_mode),
    .rotate_en_i    (rotate_en),
    .aeoi_i         (aeoi),
    .vec_base_i     (5'h11),
    .inta_i         (inta),
    .eoi_valid_i    (eoi_valid),
    .eoi_specific_i (eoi_specific),
    .eoi_level_i    (eoi_level8),
    .int_o          (int8),
    .vec_valid_o    (vvalid8),
    .vec_data_o     (vdata8),
    .irr_o          (irr8),
    .isr_o          (isr8)
  );

  pic_priority_core #(.N_IRQ(16)) u_dut16 (
    .clk            (clk),
    .rst_n          (rst16_n),
    .irq_i          (irq16),
    .imr_i          (16'h0000),
    .init_done_i    (init_done),
    .level_mode_i   (level_mode),
    .rotate_en_i    (rotate_en),
    .aeoi_i         (aeoi),
    .vec_base_i     (4'hA),
    .inta_i         (inta),
    .eoi_valid_i    (1'b0),
    .eoi_specific_i (1'b0),
    .eoi_level_i    (4'd0),
    .int_o          (int16),
    .vec_valid_o    (vvalid16),
    .vec_data_o     (vdata16),
    .irr_o          (irr16),
    .isr_o          (isr16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic reset8();
    init_done = 1'b1; level_mode = 1'b0; rotate_en = 1'b0; aeoi = 1'b0;
    inta = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level8 = 3'd0;
    irq8 = 8'h00;
    rst8_n = 1'b0;
    tick();
    tick();
    rst8_n = 1'b1;
  endtask

  task automatic reset16();
    rst16_n = 1'b0;
    tick();
    tick();
    rst16_n = 1'b1;
  endtask

  initial begin
    irq16 = 16'h0000;
    rst16_n = 1'b0;
    reset8();
    check_eq("rst_irr", 32'(irr8), 32'h00);
    check_eq("rst_isr", 32'(isr8), 32'h00);
    check_eq("rst_int", 32'(int8), 32'h0);
    check_eq("rst_vvalid", 32'(vvalid8), 32'h0);
    check_eq("rst_vdata", 32'(vdata8), 32'h00);

    // Fixed priority, edge mode, IR2 and IR5 together.
    irq8 = 8'h24;
    tick(); tick();
    check_eq("edge_irr", 32'(irr8), 32'h24);
    check_eq("edge_int", 32'(int8), 32'h1);
    pulse_inta();
    check_eq("ack1_isr", 32'(isr8), 32'h04);
    check_eq("ack1_irr", 32'(irr8), 32'h20);
    tick();
    pulse_inta();
    check_eq("ack2_vvalid", 32'(vvalid8), 32'h1);
    check_eq("ack2_vdata", 32'(vdata8), 32'h8A);
    tick();
    check_eq("strobe_one_cycle", 32'(vvalid8), 32'h0);
    check_eq("post_isr", 32'(isr8), 32'h04);
    check_eq("lower_blocked_int", 32'(int8), 32'h0);
    eoi_valid = 1'b1;
    tick();
    eoi_valid = 1'b0;
    check_eq("ns_eoi_isr", 32'(isr8), 32'h00);
    tick();
    check_eq("after_eoi_int", 32'(int8), 32'h1);

    // New edge on the line being acknowledged keeps it requested.
    reset8();
    irq8 = 8'h40; tick();
    irq8 = 8'h00; tick();
    check_eq("latched_irr", 32'(irr8), 32'h40);
    tick();
    irq8 = 8'h40;
    pulse_inta();
    check_eq("reedge_irr", 32'(irr8), 32'h40);
    check_eq("reedge_isr", 32'(isr8), 32'h40);
    pulse_inta();
    tick();
    // EOI coincident with an acknowledge: EOI first, then the set.
    irq8 = 8'h42; tick();
    check_eq("ir1_irr", 32'(irr8), 32'h42);
    eoi_valid = 1'b1;
    pulse_inta();
    eoi_valid = 1'b0;
    check_eq("eoi_ack_isr", 32'(isr8), 32'h02);
    check_eq("eoi_ack_irr", 32'(irr8), 32'h40);
    pulse_inta();
    check_eq("eoi_ack_vdata", 32'(vdata8), 32'h89);
    tick();

    // Rotation: serve IR2, EOI makes IR2 lowest, then IR3 beats IR1.
    reset8();
    rotate_en = 1'b1;
    irq8 = 8'h04;
    tick(); tick();
    pulse_inta(); tick(); pulse_inta(); tick();
    eoi_valid = 1'b1; tick(); eoi_valid = 1'b0;
    check_eq("rot_isr_clear", 32'(isr8), 32'h00);
    irq8 = 8'h0A; tick();
    pulse_inta();
    check_eq("rot_isr", 32'(isr8), 32'h08);
    pulse_inta();
    check_eq("rot_vdata", 32'(vdata8), 32'h8B);
    tick();

    // Fully nested: IR3 in service blocks IR5 but not IR1.
    reset8();
    irq8 = 8'h08;
    tick(); tick();
    pulse_inta(); pulse_inta(); tick();
    check_eq("nest_isr", 32'(isr8), 32'h08);
    irq8 = 8'h28; tick(); tick();
    check_eq("nest_ir5_int", 32'(int8), 32'h0);
    irq8 = 8'h2A; tick(); tick();
    check_eq("nest_ir1_int", 32'(int8), 32'h1);
    eoi_specific = 1'b1; eoi_level8 = 3'd3; eoi_valid = 1'b1;
    tick();
    eoi_valid = 1'b0; eoi_specific = 1'b0;
    check_eq("spec_eoi_isr", 32'(isr8), 32'h00);

    // Automatic EOI.
    reset8();
    aeoi = 1'b1;
    irq8 = 8'h10;
    tick(); tick();
    pulse_inta();
    check_eq("aeoi_isr_set", 32'(isr8), 32'h10);
    pulse_inta();
    check_eq("aeoi_isr_clr", 32'(isr8), 32'h00);
    check_eq("aeoi_vdata", 32'(vdata8), 32'h8C);
    tick();

    // Spurious acknowledge.
    reset8();
    pulse_inta();
    check_eq("spur_isr", 32'(isr8), 32'h00);
    pulse_inta();
    check_eq("spur_vvalid", 32'(vvalid8), 32'h1);
    check_eq("spur_vdata", 32'(vdata8), 32'h8F);
    tick();

    // init_done low blocks int_o and acks while irr keeps sampling.
    reset8();
    init_done = 1'b0;
    irq8 = 8'h01;
    tick(); tick();
    check_eq("noinit_irr", 32'(irr8), 32'h01);
    check_eq("noinit_int", 32'(int8), 32'h0);
    pulse_inta();
    check_eq("noinit_isr", 32'(isr8), 32'h00);
    pulse_inta();
    check_eq("noinit_vvalid", 32'(vvalid8), 32'h0);
    init_done = 1'b1;
    tick(); tick();
    check_eq("init_int", 32'(int8), 32'h1);

    // N_IRQ=16: IR12 vector, then reset in ACK1 abandons the cycle.
    reset16();
    irq16 = 16'h1000;
    tick(); tick();
    check_eq("n16_irr", 32'(irr16), 32'h1000);
    pulse_inta();
    pulse_inta();
    check_eq("n16_vvalid", 32'(vvalid16), 32'h1);
    check_eq("n16_vdata", 32'(vdata16), 32'hAC);
    tick();
    reset16();
    tick(); tick();
    pulse_inta();
    check_eq("n16_ack1_isr", 32'(isr16), 32'h1000);
    rst16_n = 1'b0;
    #2;
    check_eq("n16_rst_isr", 32'(isr16), 32'h0000);
    check_eq("n16_rst_int", 32'(int16), 32'h0);
    rst16_n = 1'b1;
    pulse_inta();
    check_eq("n16_rst_no_vvalid", 32'(vvalid16), 32'h0);
    tick();
    check_eq("n16_rst_no_vvalid2", 32'(vvalid16), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
